// File: rtl/mem_alu_pkg.sv
// Shared encodings for the register-file/ALU block: ALU function codes,
// flag bit positions and the sequencer state type.
package mem_alu_pkg;

   localparam logic [1:0] FUNC_ADD = 2'b00;
   localparam logic [1:0] FUNC_SUB = 2'b01;
   localparam logic [1:0] FUNC_AND = 2'b10;
   localparam logic [1:0] FUNC_OR  = 2'b11;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

endpackage

// File: rtl/mem_alu_if.sv
// Host write/read port and op-request port of mem_alu_unit. The master is
// the host/test controller; the slave is the unit itself.
interface mem_alu_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              wr_en;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              op_valid;
   logic              op_ready;
   logic [1:0]        op_func;
   logic [ADDR_W-1:0] op_src_a;
   logic [ADDR_W-1:0] op_src_b;
   logic [ADDR_W-1:0] op_dst;
   logic [DATA_W-1:0] result;
   logic [3:0]        flags;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr,
             op_valid, op_func, op_src_a, op_src_b, op_dst,
      input  wr_ready, rd_data, op_ready, result, flags, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr,
             op_valid, op_func, op_src_a, op_src_b, op_dst,
      output wr_ready, rd_data, op_ready, result, flags, done
   );
endinterface

// File: rtl/mem_alu_core.sv
// Combinational ALU: ADD/SUB/AND/OR modulo 2**DATA_W with {Z,N,C,V} flags.
module mem_alu_core
   import mem_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [1:0]        func,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags
);

   logic [DATA_W:0] sum;
   logic            carry;
   logic            ovf;

   always_comb begin
      sum    = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      result = '0;
      case (func)
         FUNC_ADD: begin
            sum    = {1'b0, op_a} + {1'b0, op_b};
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
            ovf    = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
         end
         FUNC_SUB: begin
            // a + ~b + 1, so the carry out doubles as "no borrow" (a >= b)
            sum    = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
            ovf    = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
         end
         FUNC_AND: result = op_a & op_b;
         default:  result = op_a | op_b;
      endcase
      flags         = '0;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[DATA_W-1];
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
   end

endmodule

// File: rtl/mem_alu_unit.sv
// Register file with host write/registered read port and a 4-state ALU sequencer.
// Optional build macro MEM_ALU_ZERO_REG_EN hard-wires address 0 to zero.
//
// state | meaning
// IDLE  | waiting for op_valid; op fields latched on accept
// READ  | operands fetched from the array at the end of this cycle
// EXEC  | ALU result and flags registered at the end of this cycle
// WB    | done=1, host writes stalled, result written to array[dst]
module mem_alu_unit
   import mem_alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input logic     clk,
   input logic     rst,
   mem_alu_if.slave bus
);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        func_q;
   logic [ADDR_W-1:0] src_a_q;
   logic [ADDR_W-1:0] src_b_q;
   logic [ADDR_W-1:0] dst_q;
   logic [DATA_W-1:0] op_a_q;
   logic [DATA_W-1:0] op_b_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        flags_q;
   logic [3:0]        alu_flags;
   logic              accept;
   logic              host_we;
   logic              wb_we;

   // Addresses outside the array (and addr 0 when hard-wired) neither store nor read back
   function automatic logic live_addr(input logic [ADDR_W-1:0] a);
`ifdef MEM_ALU_ZERO_REG_EN
      return (int'(a) < DEPTH) && (a != '0);
`else
      return int'(a) < DEPTH;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] fetch(input logic [ADDR_W-1:0] a);
      if (!live_addr(a))
         return '0;
      return mem[a];
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.op_valid) state_nxt = READ;
         READ:    state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept       = (state == IDLE) && bus.op_valid;
   assign host_we      = bus.wr_en && (state != WB) && live_addr(bus.wr_addr);
   assign wb_we        = (state == WB) && !rst && live_addr(dst_q);

   assign bus.op_ready = (state == IDLE);
   assign bus.done     = (state == WB);
   assign bus.wr_ready = (state != WB);
   assign bus.rd_data  = rd_data_q;
   assign bus.result   = result_q;
   assign bus.flags    = flags_q;

   mem_alu_core #(.DATA_W(DATA_W)) u_core (
      .op_a   (op_a_q),
      .op_b   (op_b_q),
      .func   (func_q),
      .result (alu_result),
      .flags  (alu_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_data_q <= '0;
         result_q  <= '0;
         flags_q   <= '0;
      end else begin
         state     <= state_nxt;
         rd_data_q <= fetch(bus.rd_addr);
         if (state == EXEC) begin
            result_q <= alu_result;
            flags_q  <= alu_flags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         func_q  <= bus.op_func;
         src_a_q <= bus.op_src_a;
         src_b_q <= bus.op_src_b;
         dst_q   <= bus.op_dst;
      end
      if (state == READ) begin
         op_a_q <= fetch(src_a_q);
         op_b_q <= fetch(src_b_q);
      end
   end

   // Host writes are blocked in WB, so the two write sources never collide
   always_ff @(posedge clk) begin
      if (wb_we)
         mem[dst_q] <= result_q;
      else if (host_we)
         mem[bus.wr_addr] <= bus.wr_data;
   end

endmodule

// File: tb/tb_mem_alu_unit.sv
// Self-checking bench for mem_alu_unit: directed scenarios plus a randomized
// mix of host writes, reads and ops checked against an arithmetic reference model.
module tb_mem_alu_unit;
   import mem_alu_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int MODV  = 1 << DW;
   localparam int HALF  = 1 << (DW - 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_alu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   mem_alu_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int mdl [DEPTH];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit live(input int a);
`ifdef MEM_ALU_ZERO_REG_EN
      return (a < DEPTH) && (a != 0);
`else
      return a < DEPTH;
`endif
   endfunction

   function automatic int mread(input int a);
      return live(a) ? mdl[a] : 0;
   endfunction

   function automatic void mwrite(input int a, input int d);
      if (live(a)) mdl[a] = d % MODV;
   endfunction

   // Reference: plain integer arithmetic on unsigned and signed views; commits dst
   function automatic void model_op(input logic [1:0] f, input int a, input int b, input int d,
                                    output logic [DW-1:0] res, output logic [3:0] fl);
      int x, y, sx, sy, s, ss, r;
      bit c, v;
      x = mread(a);
      y = mread(b);
      sx = (x >= HALF) ? x - MODV : x;
      sy = (y >= HALF) ? y - MODV : y;
      s = 0; ss = 0; c = 0; v = 0;
      case (f)
         FUNC_ADD: begin s = x + y; ss = sx + sy; c = (s >= MODV); v = (ss >= HALF) || (ss < -HALF); end
         FUNC_SUB: begin s = x - y; ss = sx - sy; c = (x >= y);    v = (ss >= HALF) || (ss < -HALF); end
         FUNC_AND: s = x & y;
         default:  s = x | y;
      endcase
      r   = ((s % MODV) + MODV) % MODV;
      res = DW'(r);
      fl  = {r == 0, r >= HALF, c, v};
      mwrite(d, r);
   endfunction

   task automatic host_write(input int a, input int d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = DW'(d);
      step();
      bus.wr_en = 1'b0;
      mwrite(a, d);
   endtask

   task automatic do_read(input int a, output logic [DW-1:0] d);
      bus.rd_addr = AW'(a);
      step();
      d = bus.rd_data;
   endtask

   // lat = samples after the accept edge until done is seen (99 if it never comes)
   task automatic run_op(input logic [1:0] f, input int a, input int b, input int d,
                         output logic [DW-1:0] res, output logic [3:0] fl, output int lat);
      lat = 99;
      res = '0;
      fl  = '0;
      bus.op_func  = f;
      bus.op_src_a = AW'(a);
      bus.op_src_b = AW'(b);
      bus.op_dst   = AW'(d);
      bus.op_valid = 1'b1;
      for (int i = 0; i < 8 && !bus.op_ready; i++) step();
      step();
      bus.op_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (bus.done) begin
            lat = i;
            res = bus.result;
            fl  = bus.flags;
            break;
         end
         step();
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_tests++; if (bus.rd_data !== '0)   begin n_fail++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data); end
      n_tests++; if (bus.result !== '0)    begin n_fail++; $display("FAIL reset_result got %h exp 00", bus.result); end
      n_tests++; if (bus.flags !== 4'b0)   begin n_fail++; $display("FAIL reset_flags got %b exp 0000", bus.flags); end
      n_tests++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready got %b exp 1", bus.op_ready); end
      n_tests++; if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
      n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_host_write();
      logic [DW-1:0] d;
      host_write(4, 141);
      host_write(6, 208);
      host_write(8, 32);
      host_write(12, 'h11);
      host_write(13, 'h33);
      do_read(4, d);
      n_tests++; if (d !== 8'h8D) begin n_fail++; $display("FAIL read_r4 got %h exp 8d", d); end
      do_read(6, d);
      n_tests++; if (d !== 8'hD0) begin n_fail++; $display("FAIL read_r6 got %h exp d0", d); end
      do_read(8, d);
      n_tests++; if (d !== 8'h20) begin n_fail++; $display("FAIL read_r8 got %h exp 20", d); end
      n_tests++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL wr_op_ready got %b exp 1", bus.op_ready); end
      n_tests++; if (bus.flags !== 4'b0)    begin n_fail++; $display("FAIL wr_flags got %b exp 0000", bus.flags); end
   endtask

   task automatic test_add();
      logic [DW-1:0] r, er, d;
      logic [3:0]    fl, ef;
      int            lat;
      model_op(FUNC_ADD, 4, 6, 10, er, ef);
      run_op(FUNC_ADD, 4, 6, 10, r, fl, lat);
      n_tests++; if (lat !== 3)  begin n_fail++; $display("FAIL add_latency got %0d exp 3", lat); end
      n_tests++; if (r !== er)   begin n_fail++; $display("FAIL add_result got %h exp %h", r, er); end
      n_tests++; if (fl !== ef)  begin n_fail++; $display("FAIL add_flags got %b exp %b", fl, ef); end
      do_read(10, d);
      n_tests++; if (d !== er)   begin n_fail++; $display("FAIL add_wb_r10 got %h exp %h", d, er); end
   endtask

   task automatic test_sub_alias();
      logic [DW-1:0] r, er, d;
      logic [3:0]    fl, ef;
      int            lat;
      model_op(FUNC_SUB, 6, 8, 6, er, ef);
      run_op(FUNC_SUB, 6, 8, 6, r, fl, lat);
      n_tests++; if (r !== er)  begin n_fail++; $display("FAIL sub_alias_result got %h exp %h", r, er); end
      n_tests++; if (fl !== ef) begin n_fail++; $display("FAIL sub_alias_flags got %b exp %b", fl, ef); end
      do_read(6, d);
      n_tests++; if (d !== er)  begin n_fail++; $display("FAIL sub_alias_r6 got %h exp %h", d, er); end
      model_op(FUNC_SUB, 4, 4, 11, er, ef);
      run_op(FUNC_SUB, 4, 4, 11, r, fl, lat);
      n_tests++; if (r !== er)  begin n_fail++; $display("FAIL sub_zero_result got %h exp %h", r, er); end
      n_tests++; if (fl !== ef) begin n_fail++; $display("FAIL sub_zero_flags got %b exp %b", fl, ef); end
   endtask

   task automatic test_logic();
      logic [DW-1:0] r, er;
      logic [3:0]    fl, ef;
      int            lat;
      host_write(6, 208);
      model_op(FUNC_AND, 4, 6, 15, er, ef);
      run_op(FUNC_AND, 4, 6, 15, r, fl, lat);
      n_tests++; if (r !== er)  begin n_fail++; $display("FAIL and_result got %h exp %h", r, er); end
      n_tests++; if (fl !== ef) begin n_fail++; $display("FAIL and_flags got %b exp %b", fl, ef); end
      model_op(FUNC_OR, 4, 8, 16, er, ef);
      run_op(FUNC_OR, 4, 8, 16, r, fl, lat);
      n_tests++; if (r !== er)  begin n_fail++; $display("FAIL or_result got %h exp %h", r, er); end
      n_tests++; if (fl !== ef) begin n_fail++; $display("FAIL or_flags got %b exp %b", fl, ef); end
   endtask

   task automatic test_busy();
      logic [DW-1:0] er;
      logic [3:0]    ef;
      int            dones;
      model_op(FUNC_ADD, 4, 8, 17, er, ef);
      bus.op_func  = FUNC_ADD;
      bus.op_src_a = AW'(4);
      bus.op_src_b = AW'(8);
      bus.op_dst   = AW'(17);
      bus.op_valid = 1'b1;
      step();
      step();
      step();
      n_tests++; if (bus.done !== 1'b1)     begin n_fail++; $display("FAIL busy_done got %b exp 1", bus.done); end
      n_tests++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL busy_wr_ready_wb got %b exp 0", bus.wr_ready); end
      n_tests++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL busy_op_ready_wb got %b exp 0", bus.op_ready); end
      n_tests++; if (bus.result !== er)     begin n_fail++; $display("FAIL busy_result got %h exp %h", bus.result, er); end
      n_tests++; if (bus.flags !== ef)      begin n_fail++; $display("FAIL busy_flags got %b exp %b", bus.flags, ef); end
      bus.op_valid = 1'b0;
      bus.wr_en    = 1'b1;
      bus.wr_addr  = AW'(12);
      bus.wr_data  = 8'h5A;
      bus.rd_addr  = AW'(12);
      step();
      n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL busy_wr_ready_idle got %b exp 1", bus.wr_ready); end
      n_tests++; if (bus.done !== 1'b0)     begin n_fail++; $display("FAIL busy_done_after got %b exp 0", bus.done); end
      n_tests++; if (bus.rd_data !== 8'h11) begin n_fail++; $display("FAIL busy_r12_in_wb got %h exp 11", bus.rd_data); end
      step();
      bus.wr_en = 1'b0;
      mwrite(12, 'h5A);
      n_tests++; if (bus.rd_data !== 8'h11) begin n_fail++; $display("FAIL same_edge_read_old got %h exp 11", bus.rd_data); end
      step();
      n_tests++; if (bus.rd_data !== 8'h5A) begin n_fail++; $display("FAIL held_write_r12 got %h exp 5a", bus.rd_data); end
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.done) dones++;
         step();
      end
      n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL busy_second_done got %0d exp 0", dones); end
   endtask

   task automatic test_reset_mid_op();
      logic [DW-1:0] d;
      int            dones;
      bus.op_func  = FUNC_ADD;
      bus.op_src_a = AW'(4);
      bus.op_src_b = AW'(6);
      bus.op_dst   = AW'(13);
      bus.op_valid = 1'b1;
      step();
      bus.op_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got %b exp 1", bus.op_ready); end
      n_tests++; if (bus.done !== 1'b0)     begin n_fail++; $display("FAIL midrst_done got %b exp 0", bus.done); end
      n_tests++; if (bus.flags !== 4'b0)    begin n_fail++; $display("FAIL midrst_flags got %b exp 0000", bus.flags); end
      n_tests++; if (bus.result !== '0)     begin n_fail++; $display("FAIL midrst_result got %h exp 00", bus.result); end
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.done) dones++;
         step();
      end
      n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_late_done got %0d exp 0", dones); end
      do_read(13, d);
      n_tests++; if (d !== 8'h33) begin n_fail++; $display("FAIL midrst_r13 got %h exp 33", d); end
   endtask

   task automatic test_zero_reg();
      logic [DW-1:0] r, er, d;
      logic [3:0]    fl, ef;
      int            lat;
      host_write(0, 'hFF);
      model_op(FUNC_ADD, 0, 8, 14, er, ef);
      run_op(FUNC_ADD, 0, 8, 14, r, fl, lat);
      n_tests++; if (r !== er)  begin n_fail++; $display("FAIL zero_reg_result got %h exp %h", r, er); end
      n_tests++; if (fl !== ef) begin n_fail++; $display("FAIL zero_reg_flags got %b exp %b", fl, ef); end
      do_read(0, d);
      n_tests++; if (d !== DW'(mread(0))) begin n_fail++; $display("FAIL zero_reg_r0 got %h exp %h", d, DW'(mread(0))); end
   endtask

   task automatic test_random();
      logic [DW-1:0] r, er, d;
      logic [3:0]    fl, ef;
      int            lat, a, b, dst, kind;
      logic [1:0]    f;
      for (int i = 0; i < DEPTH; i++) host_write(i, int'($urandom_range(0, MODV - 1)));
      for (int it = 0; it < 60; it++) begin
         kind = int'($urandom_range(0, 2));
         if (kind == 0) begin
            host_write(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, MODV - 1)));
         end else if (kind == 1) begin
            f   = 2'($urandom_range(0, 3));
            a   = int'($urandom_range(0, DEPTH - 1));
            b   = int'($urandom_range(0, DEPTH - 1));
            dst = int'($urandom_range(0, DEPTH - 1));
            model_op(f, a, b, dst, er, ef);
            run_op(f, a, b, dst, r, fl, lat);
            n_tests++; if (lat !== 3)  begin n_fail++; $display("FAIL rand_latency it=%0d got %0d exp 3", it, lat); end
            n_tests++; if (r !== er)   begin n_fail++; $display("FAIL rand_result it=%0d f=%0d a=%0d b=%0d got %h exp %h", it, f, a, b, r, er); end
            n_tests++; if (fl !== ef)  begin n_fail++; $display("FAIL rand_flags it=%0d f=%0d a=%0d b=%0d got %b exp %b", it, f, a, b, fl, ef); end
            do_read(dst, d);
            n_tests++; if (d !== DW'(mread(dst))) begin n_fail++; $display("FAIL rand_wb it=%0d r%0d got %h exp %h", it, dst, d, DW'(mread(dst))); end
         end else begin
            a = int'($urandom_range(0, DEPTH - 1));
            do_read(a, d);
            n_tests++; if (d !== DW'(mread(a))) begin n_fail++; $display("FAIL rand_read it=%0d r%0d got %h exp %h", it, a, d, DW'(mread(a))); end
         end
      end
   endtask

   initial begin
      rst          = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.rd_addr  = '0;
      bus.op_valid = 1'b0;
      bus.op_func  = FUNC_ADD;
      bus.op_src_a = '0;
      bus.op_src_b = '0;
      bus.op_dst   = '0;
      for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
      test_reset();
      test_host_write();
      test_add();
      test_sub_alias();
      test_logic();
      test_busy();
      test_reset_mid_op();
      test_zero_reg();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_alu_unit.md
Name: mem_alu_unit

Overview:
Parametrised register-file/ALU block. It holds a DEPTH x DATA_W register array with a host write port and a registered host read port. A sequenced ALU engine accepts op requests (src_a, src_b, dst, func), executes them over a fixed 4-state pipeline, writes the result back to the array and updates the flag register. It is the generalised, clocked successor of the team's single-width memory unit and sits between the host/test controller and the datapath.

Parameters:
DATA_W, 8, register and ALU width in bits (>=2)
ADDR_W, 5, address width
DEPTH, 32, number of registers (<= 2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  host write strobe
wr_ready  out  1  host write accepted this cycle (low only in WB)
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write data
rd_addr  in  ADDR_W  host read address
rd_data  out  DATA_W  registered read data
op_valid  in  1  op request
op_ready  out  1  engine idle, can accept an op
op_func  in  2  00 ADD, 01 SUB (a-b), 10 AND, 11 OR
op_src_a, op_src_b, op_dst  in  ADDR_W each  operand and destination addresses
result  out  DATA_W  last ALU result
flags  out  4  {Z,N,C,V}, bit3..bit0
done  out  1  high for the single WB cycle of each op

Behaviour:
- Clock is one domain only. Reset is synchronous and active-high. rst=1 at a clk edge forces state IDLE, rd_data=0, result=0, flags=0. Array contents are not reset.
- Combinational outputs: op_ready=(state==IDLE), done=(state==WB), wr_ready=(state!=WB).
- Host write: when wr_en && wr_ready && wr_addr<DEPTH, the edge writes array[wr_addr]. wr_en in WB is ignored; the host must hold the request. Out-of-range addresses: writes are dropped and reads return 0.
- rd_data is loaded with array[rd_addr] every edge, giving 1-cycle latency. A same-address write on that edge returns the old data.
- FSM transitions:
  - IDLE -> READ on op_valid&&op_ready. That edge latches func, src_a, src_b and dst.
  - READ -> EXEC. That edge latches opA=array[src_a] and opB=array[src_b]. These values include any host write committed on or before the accept edge. A host write on the READ edge itself is not seen.
  - EXEC -> WB. That edge registers result and flags.
  - WB -> IDLE. That edge writes array[dst]=result.
  - An op accepted at edge k has done=1 in the cycle after edge k+2. The next op can be accepted in the cycle after edge k+3, giving a 4-cycle throughput.
- ALU arithmetic is modulo 2**DATA_W.
  - ADD: C = carry out.
  - SUB: computed as a+~b+1, so C=1 when a>=b unsigned.
  - V = signed overflow for ADD/SUB. C=V=0 for AND/OR.
  - Z = (result==0). N = result[DATA_W-1].
- flags and result hold their values outside EXEC.
- Reset mid-op (any non-IDLE state) aborts the op: no writeback and done=0 next cycle.
- op_valid while busy is ignored; it is not queued.
- src/dst aliasing is legal: dst==src_a writes after both operands are captured.

Optional Feature:
Macro MEM_ALU_ZERO_REG_EN.
- Defined: address 0 is hard-wired to zero. Reads and operand fetches of addr 0 return 0. Host writes and writebacks to addr 0 are discarded, but flags/result/done still update.
- Undefined: address 0 is an ordinary register.

Decomposition:
- Package mem_alu_pkg: func encodings (FUNC_ADD/SUB/AND/OR), flag bit indices (FLAG_Z=3, N=2, C=1, V=0), FSM state enum (IDLE, READ, EXEC, WB).
- One sub-module: mem_alu_core, a purely combinational (opA, opB, func) -> (result, flags) block instantiated in EXEC. The array and FSM stay in the top.

Test Plan:
- Reset and host writes: assert rst 2 cycles, then write 141->R4, 208->R6, 32->R8. Read each back -> rd_data 0x8D, 0xD0, 0x20 one cycle after rd_addr is applied. op_ready=1, flags=0.
- ADD R4+R6->R10 -> done exactly 3 cycles after the accept edge, result 0x5D, flags 4'b0011. R10 reads 0x5D after WB.
- SUB R6-R8->R6, with aliasing -> result 0xB0, flags 4'b0110, R6=0xB0. Then SUB R4-R4->R11 -> result 0, flags 4'b1010.
- AND R4&R6, with R6 restored to 208 -> 0x80, flags 4'b0100. OR R4|R8 -> 0xAD, flags 4'b0100.
- Host wr_en to R12 held during WB -> wr_ready=0 in WB and the write lands the next cycle. op_valid asserted while busy -> ignored, no second done.
- rst asserted in EXEC of ADD R4+R6->R13 -> IDLE next cycle, done never pulses, R13 unchanged, flags=0. With MEM_ALU_ZERO_REG_EN, write 0xFF->R0 then ADD R0+R8 -> result 0x20.
